// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap_pkg
// Description : Opcodes, T-state indices and control-word type for the SAP
//               sequencer and its decode ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    localparam logic [3:0] c_OP_LDA = 4'h0;
    localparam logic [3:0] c_OP_ADD = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_JMP = 4'h3;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    localparam int unsigned c_T1 = 0;
    localparam int unsigned c_T2 = 1;
    localparam int unsigned c_T3 = 2;
    localparam int unsigned c_T4 = 3;
    localparam int unsigned c_T5 = 4;
    localparam int unsigned c_T6 = 5;

    typedef struct packed {
        logic pc_inc;
        logic pc_oe;
        logic pc_we;
        logic mar_we;
        logic mem_oe;
        logic ir_we;
        logic ir_oe;
        logic acc_we;
        logic acc_oe;
        logic b_we;
        logic alu_oe;
        logic alu_sub;
        logic out_we;
    } ctrl_word_t;

    // Write strobes and pc_inc may only fire in the cycle the sequencer leaves the state.
    function automatic ctrl_word_t gate_writes(input ctrl_word_t cw, input logic allow);
        ctrl_word_t g;
        g        = cw;
        g.pc_inc = cw.pc_inc & allow;
        g.pc_we  = cw.pc_we  & allow;
        g.mar_we = cw.mar_we & allow;
        g.ir_we  = cw.ir_we  & allow;
        g.acc_we = cw.acc_we & allow;
        g.b_we   = cw.b_we   & allow;
        g.out_we = cw.out_we & allow;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap_ctrl_rom.sv
`default_nettype none
// ============================================================================
// Module      : sap_ctrl_rom
// Description : Combinational decode of (T-state index, opcode) into the
//               control word and the opcode's last-active-state flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_ctrl_rom
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int IDX_W    = 3
) (
    input  logic [IDX_W-1:0]    tstate_idx,
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          ctrl,
    output logic                last_active
);

    logic w_lda, w_add, w_sub, w_jmp, w_out, w_hlt, w_nop;

    always_comb begin
        w_lda = (opcode == OPCODE_W'(c_OP_LDA));
        w_add = (opcode == OPCODE_W'(c_OP_ADD));
        w_sub = (opcode == OPCODE_W'(c_OP_SUB));
        w_jmp = (opcode == OPCODE_W'(c_OP_JMP));
        w_out = (opcode == OPCODE_W'(c_OP_OUT));
        w_hlt = (opcode == OPCODE_W'(c_OP_HLT));
        w_nop = ~(w_lda | w_add | w_sub | w_jmp | w_out | w_hlt);
    end

    always_comb begin
        ctrl        = '0;
        last_active = 1'b0;
        if (tstate_idx == IDX_W'(c_T1)) begin
            ctrl.pc_oe  = 1'b1;
            ctrl.mar_we = 1'b1;
        end else if (tstate_idx == IDX_W'(c_T2)) begin
            ctrl.pc_inc = 1'b1;
        end else if (tstate_idx == IDX_W'(c_T3)) begin
            ctrl.mem_oe = 1'b1;
            ctrl.ir_we  = 1'b1;
            last_active = w_nop;
        end else if (tstate_idx == IDX_W'(c_T4)) begin
            ctrl.ir_oe  = w_lda | w_add | w_sub | w_jmp;
            ctrl.mar_we = w_lda | w_add | w_sub;
            ctrl.pc_we  = w_jmp;
            ctrl.acc_oe = w_out;
            ctrl.out_we = w_out;
            // HLT ends here too; the sequencer parks before this matters.
            last_active = w_jmp | w_out | w_hlt;
        end else if (tstate_idx == IDX_W'(c_T5)) begin
            ctrl.mem_oe  = w_lda | w_add | w_sub;
            ctrl.acc_we  = w_lda;
            ctrl.b_we    = w_add | w_sub;
            ctrl.alu_sub = w_sub;
            last_active  = w_lda;
        end else if (tstate_idx == IDX_W'(c_T6)) begin
            ctrl.alu_oe  = w_add | w_sub;
            ctrl.acc_we  = w_add | w_sub;
            ctrl.alu_sub = w_sub;
            last_active  = w_add | w_sub;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sap_sequencer
// Description : One-hot T-state sequencer for the SAP datapath with free-run,
//               single-step, halt latching and optional early end.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_sequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int N_TSTATES = 6,
    parameter int EARLY_END = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 run,
    input  logic                 mode,
    input  logic                 step,
    input  logic [OPCODE_W-1:0]  ir_opcode,
    output logic [N_TSTATES-1:0] tstate,
    output logic                 pc_inc,
    output logic                 pc_oe,
    output logic                 pc_we,
    output logic                 mar_we,
    output logic                 mem_oe,
    output logic                 ir_we,
    output logic                 ir_oe,
    output logic                 acc_we,
    output logic                 acc_oe,
    output logic                 b_we,
    output logic                 alu_oe,
    output logic                 alu_sub,
    output logic                 out_we,
    output logic                 hlt
);

    localparam int c_IDX_W = $clog2(N_TSTATES);

    logic [N_TSTATES-1:0] r_tstate;
    logic                 r_halted;
    logic                 r_step_q;

    logic [c_IDX_W-1:0] w_idx;
    ctrl_word_t         w_rom;
    ctrl_word_t         w_ctrl;
    logic               w_last;
    logic               w_halt_now;
    logic               w_hlt;
    logic               w_step_edge;
    logic               w_advance;
    logic               w_wrap;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_TSTATES; i++) begin
            if (r_tstate[i]) w_idx = c_IDX_W'(i);
        end
    end

    sap_ctrl_rom #(
        .OPCODE_W (OPCODE_W),
        .IDX_W    (c_IDX_W)
    ) u_rom (
        .tstate_idx  (w_idx),
        .opcode      (ir_opcode),
        .ctrl        (w_rom),
        .last_active (w_last)
    );

    // The opcode is only trustworthy from T4, so halt takes effect on T4 entry.
    assign w_halt_now  = (r_tstate != '0) && (w_idx == c_IDX_W'(c_T4))
                         && (ir_opcode == OPCODE_W'(c_OP_HLT));
    assign w_hlt       = r_halted | w_halt_now;
    assign w_step_edge = step & ~r_step_q;
    assign w_advance   = run & (~mode | w_step_edge) & ~w_hlt;
    assign w_wrap      = (w_idx == c_IDX_W'(N_TSTATES - 1)) || ((EARLY_END != 0) && w_last);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_tstate <= N_TSTATES'(1);
            r_halted <= 1'b0;
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
            if (w_halt_now) begin
                r_halted <= 1'b1;
                r_tstate <= '0;
            end else if (w_advance) begin
                r_tstate <= w_wrap ? N_TSTATES'(1) : (r_tstate << 1);
            end
        end
    end

    assign w_ctrl  = (RESET && !w_hlt) ? gate_writes(w_rom, w_advance) : '0;

    assign tstate  = w_hlt ? '0 : r_tstate;
    assign hlt     = w_hlt;
    assign pc_inc  = w_ctrl.pc_inc;
    assign pc_oe   = w_ctrl.pc_oe;
    assign pc_we   = w_ctrl.pc_we;
    assign mar_we  = w_ctrl.mar_we;
    assign mem_oe  = w_ctrl.mem_oe;
    assign ir_we   = w_ctrl.ir_we;
    assign ir_oe   = w_ctrl.ir_oe;
    assign acc_we  = w_ctrl.acc_we;
    assign acc_oe  = w_ctrl.acc_oe;
    assign b_we    = w_ctrl.b_we;
    assign alu_oe  = w_ctrl.alu_oe;
    assign alu_sub = w_ctrl.alu_sub;
    assign out_we  = w_ctrl.out_we;

endmodule
`default_nettype wire

// File: tb/tb_sap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_sequencer
// Description : Scoreboard bench driving an EARLY_END=1 and an EARLY_END=0
//               sequencer side by side against a microcode-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_sequencer;

    localparam logic [12:0] PC_INC  = 13'h1000;
    localparam logic [12:0] PC_OE   = 13'h0800;
    localparam logic [12:0] PC_WE   = 13'h0400;
    localparam logic [12:0] MAR_WE  = 13'h0200;
    localparam logic [12:0] MEM_OE  = 13'h0100;
    localparam logic [12:0] IR_WE   = 13'h0080;
    localparam logic [12:0] IR_OE   = 13'h0040;
    localparam logic [12:0] ACC_WE  = 13'h0020;
    localparam logic [12:0] ACC_OE  = 13'h0010;
    localparam logic [12:0] B_WE    = 13'h0008;
    localparam logic [12:0] ALU_OE  = 13'h0004;
    localparam logic [12:0] ALU_SUB = 13'h0002;
    localparam logic [12:0] OUT_WE  = 13'h0001;
    localparam logic [12:0] WE_MASK = PC_INC | PC_WE | MAR_WE | IR_WE | ACC_WE | B_WE | OUT_WE;

    typedef struct packed {
        logic [5:0]  ts;
        logic [12:0] cw;
        logic        hlt;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET, run, mode, step;
    logic [3:0] op0, op1;
    logic [5:0] ts0, ts1;
    logic [12:0] cw0, cw1;
    logic       hlt0, hlt1;
    logic a_pc_inc, a_pc_oe, a_pc_we, a_mar_we, a_mem_oe, a_ir_we, a_ir_oe;
    logic a_acc_we, a_acc_oe, a_b_we, a_alu_oe, a_alu_sub, a_out_we;
    logic b_pc_inc, b_pc_oe, b_pc_we, b_mar_we, b_mem_oe, b_ir_we, b_ir_oe;
    logic b_acc_we, b_acc_oe, b_b_we, b_alu_oe, b_alu_sub, b_out_we;

    always #5 CLK = ~CLK;

    sap_sequencer #(.OPCODE_W(4), .N_TSTATES(6), .EARLY_END(1)) u_dut_ee (
        .CLK(CLK), .RESET(RESET), .run(run), .mode(mode), .step(step), .ir_opcode(op0),
        .tstate(ts0), .pc_inc(a_pc_inc), .pc_oe(a_pc_oe), .pc_we(a_pc_we), .mar_we(a_mar_we),
        .mem_oe(a_mem_oe), .ir_we(a_ir_we), .ir_oe(a_ir_oe), .acc_we(a_acc_we), .acc_oe(a_acc_oe),
        .b_we(a_b_we), .alu_oe(a_alu_oe), .alu_sub(a_alu_sub), .out_we(a_out_we), .hlt(hlt0)
    );

    sap_sequencer #(.OPCODE_W(4), .N_TSTATES(6), .EARLY_END(0)) u_dut_full (
        .CLK(CLK), .RESET(RESET), .run(run), .mode(mode), .step(step), .ir_opcode(op1),
        .tstate(ts1), .pc_inc(b_pc_inc), .pc_oe(b_pc_oe), .pc_we(b_pc_we), .mar_we(b_mar_we),
        .mem_oe(b_mem_oe), .ir_we(b_ir_we), .ir_oe(b_ir_oe), .acc_we(b_acc_we), .acc_oe(b_acc_oe),
        .b_we(b_b_we), .alu_oe(b_alu_oe), .alu_sub(b_alu_sub), .out_we(b_out_we), .hlt(hlt1)
    );

    assign cw0 = {a_pc_inc, a_pc_oe, a_pc_we, a_mar_we, a_mem_oe, a_ir_we, a_ir_oe,
                  a_acc_we, a_acc_oe, a_b_we, a_alu_oe, a_alu_sub, a_out_we};
    assign cw1 = {b_pc_inc, b_pc_oe, b_pc_we, b_mar_we, b_mem_oe, b_ir_we, b_ir_oe,
                  b_acc_we, b_acc_oe, b_b_we, b_alu_oe, b_alu_sub, b_out_we};

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Model state: current T-state number (1..6), halted flag, last sampled step.
    int         m_t[2];
    bit         m_halt[2];
    bit         m_prev;
    logic [3:0] cur_op[2];
    logic [3:0] next_op;

    // Micro-operation table straight from the instruction descriptions.
    function automatic logic [12:0] micro(input logic [3:0] op, input int t);
        logic [12:0] m;
        m = '0;
        case (t)
            1: m = PC_OE | MAR_WE;
            2: m = PC_INC;
            3: m = MEM_OE | IR_WE;
            4: case (op)
                   4'h0, 4'h1, 4'h2: m = IR_OE | MAR_WE;
                   4'h3:             m = IR_OE | PC_WE;
                   4'hE:             m = ACC_OE | OUT_WE;
                   default:          m = '0;
               endcase
            5: case (op)
                   4'h0:    m = MEM_OE | ACC_WE;
                   4'h1:    m = MEM_OE | B_WE;
                   4'h2:    m = MEM_OE | B_WE | ALU_SUB;
                   default: m = '0;
               endcase
            6: case (op)
                   4'h1:    m = ALU_OE | ACC_WE;
                   4'h2:    m = ALU_OE | ACC_WE | ALU_SUB;
                   default: m = '0;
               endcase
            default: m = '0;
        endcase
        return m;
    endfunction

    // Last active state = latest execute state with any micro-op, else end of fetch.
    function automatic int last_t(input logic [3:0] op);
        if (op == 4'hF) return 4;
        for (int t = 6; t >= 4; t--) begin
            if (micro(op, t) != '0) return t;
        end
        return 3;
    endfunction

    task automatic drive(input bit rn, input bit r, input bit md, input bit s);
        exp_t e[2];
        bit   hn[2];
        bit   adv;
        @(posedge CLK);
        #1;
        cyc++;
        RESET = rn; run = r; mode = md; step = s;
        for (int d = 0; d < 2; d++) begin
            if (m_t[d] == 1 && !m_halt[d]) cur_op[d] = next_op;
        end
        op0 = cur_op[0];
        op1 = cur_op[1];
        adv = rn && r && (!md || (s && !m_prev));
        for (int d = 0; d < 2; d++) begin
            hn[d] = m_halt[d] || (m_t[d] == 4 && cur_op[d] == 4'hF);
            if (hn[d]) begin
                e[d].ts = '0; e[d].cw = '0; e[d].hlt = 1'b1;
            end else begin
                e[d].ts  = 6'(1 << (m_t[d] - 1));
                e[d].hlt = 1'b0;
                e[d].cw  = rn ? micro(cur_op[d], m_t[d]) : '0;
                if (!adv) e[d].cw = e[d].cw & ~WE_MASK;
            end
        end
        q0.push_back(e[0]);
        q1.push_back(e[1]);
        for (int d = 0; d < 2; d++) begin
            if (!rn) begin
                m_t[d] = 1; m_halt[d] = 1'b0;
            end else if (hn[d]) begin
                m_halt[d] = 1'b1;
            end else if (adv) begin
                if (m_t[d] == 6 || (d == 0 && m_t[d] == last_t(cur_op[d]))) m_t[d] = 1;
                else m_t[d] = m_t[d] + 1;
            end
        end
        m_prev = rn ? s : 1'b0;
    endtask

    task automatic check_out(input string name, input exp_t e, input logic [5:0] ts,
                             input logic [12:0] cw, input logic h);
        checks++;
        if (ts !== e.ts) begin
            failures++;
            $display("FAIL %s_tstate cyc=%0d actual=%b required=%b", name, cyc, ts, e.ts);
        end
        checks++;
        if (cw !== e.cw) begin
            failures++;
            $display("FAIL %s_ctrl cyc=%0d actual=%b required=%b", name, cyc, cw, e.cw);
        end
        checks++;
        if (h !== e.hlt) begin
            failures++;
            $display("FAIL %s_hlt cyc=%0d actual=%b required=%b", name, cyc, h, e.hlt);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_out("ee", e, ts0, cw0, hlt0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_out("full", e, ts1, cw1, hlt1);
        end
    end

    bit rn_r, run_r, mode_r, step_r;
    int k;

    initial begin
        RESET = 1'b0; run = 1'b0; mode = 1'b0; step = 1'b0;
        op0 = 4'h0; op1 = 4'h0; next_op = 4'h0;
        repeat (2) @(posedge CLK);
        m_t[0] = 1; m_t[1] = 1; m_halt[0] = 1'b0; m_halt[1] = 1'b0; m_prev = 1'b0;
        cur_op[0] = 4'h0; cur_op[1] = 4'h0;

        // LDA then SUB in free-run
        drive(0, 1, 0, 0);
        next_op = 4'h0; repeat (12) drive(1, 1, 0, 0);
        next_op = 4'h2; repeat (14) drive(1, 1, 0, 0);

        // Single-step: park in T2 for 10 cycles, then one step edge
        drive(0, 1, 1, 0);
        next_op = 4'h0;
        drive(1, 1, 1, 1);
        repeat (10) drive(1, 1, 1, 0);
        drive(1, 1, 1, 1);
        drive(1, 1, 1, 1);
        drive(1, 1, 1, 0);
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 0);

        // HLT with inputs toggling, then reset out of it
        drive(0, 1, 0, 0);
        next_op = 4'hF;
        repeat (4) drive(1, 1, 0, 0);
        repeat (20) drive(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(0, 1, 0, 0);
        next_op = 4'h0; repeat (3) drive(1, 1, 0, 0);

        // Reset during T5 of ADD; run low across T3
        drive(0, 1, 0, 0);
        next_op = 4'h1; repeat (4) drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        repeat (3) drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        next_op = 4'h0;
        repeat (2) drive(1, 1, 0, 0);
        repeat (5) drive(1, 0, 0, 0);
        repeat (4) drive(1, 1, 0, 0);

        // JMP then an undefined opcode
        drive(0, 1, 0, 0);
        next_op = 4'h3; repeat (8) drive(1, 1, 0, 0);
        next_op = 4'h7; repeat (10) drive(1, 1, 0, 0);
        next_op = 4'hE; repeat (8) drive(1, 1, 0, 0);

        // Randomised traffic
        mode_r = 1'b0; step_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) mode_r = ~mode_r;
            if ($urandom_range(0, 2) == 0) step_r = ~step_r;
            run_r = ($urandom_range(0, 7) != 0);
            rn_r  = ($urandom_range(0, 79) != 0);
            k = int'($urandom_range(0, 15));
            if (k == 15 && $urandom_range(0, 3) != 0) k = 1;
            next_op = 4'(k);
            drive(rn_r, run_r, mode_r, step_r);
        end

        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
